// File: rtl/adder_pkg.sv
// adder_pkg: op-mode encoding and chunk sizing shared by the pipelined carry adder
package adder_pkg;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_e;
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/pipelined_carry_adder_carry_chunk.sv
// carry_chunk: combinational W-bit ripple of full-adder bits, exposing the carry into the top bit
module carry_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);
  logic [W:0] c;
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
  assign co = c[W];
  assign c_msb_in = c[W-1];
endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/sub split into STAGES carry-registered chunks with valid/ready flow
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int C = chunk_w(WIDTH, STAGES);
  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_chk
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES");
  end
  logic [STAGES-1:0] v, adv, c;
  logic [WIDTH-1:0] w [STAGES];
  logic [WIDTH-1:0] bb [STAGES];
  logic ov_q;
  always_comb begin
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) adv[i] = !v[i] || adv[i+1];
  end
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] wi, bi, wd, w_q, b_q;
    logic [C-1:0] s;
    logic vi, ci, co, cm, v_q, c_q, unused_b;
    if (k == 0) begin : g_in
      assign vi = in_valid;
      assign wi = a;
      assign bi = (op_e'(sub) == SUB) ? ~b : b;
      assign ci = (op_e'(sub) == SUB) ? ~cin : cin;
    end else begin : g_mid
      assign vi = v[k-1];
      assign wi = w[k-1];
      assign bi = bb[k-1];
      assign ci = c[k-1];
    end
    carry_chunk #(.W(C)) u_chunk (
      .x(wi[k*C +: C]), .y(bi[k*C +: C]), .ci(ci), .s(s), .co(co), .c_msb_in(cm)
    );
    // the word register keeps upper a chunks and replaces consumed ones with sum chunks
    always_comb begin
      wd = wi;
      wd[k*C +: C] = s;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        w_q <= '0;
        b_q <= '0;
        c_q <= 1'b0;
      end else if (adv[k]) begin
        v_q <= vi;
        w_q <= wd;
        b_q <= bi;
        c_q <= co;
      end
    end
    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ov_q <= 1'b0;
        else if (adv[k]) ov_q <= cm ^ co;
      end
    end
    assign v[k] = v_q;
    assign w[k] = w_q;
    assign bb[k] = b_q;
    assign c[k] = c_q;
    assign unused_b = ^b_q;
  end
  assign in_ready = adv[0];
  assign out_valid = v[STAGES-1];
  assign sum = w[STAGES-1];
  assign cout = c[STAGES-1];
  assign overflow = ov_q;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: randomized and directed checks of 8/2 and 4/4 adder pipelines against an arithmetic model
module tb_pipelined_carry_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv8, ir8, vo8, or8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic iv4, ir4, vo4, or4, cin4, sub4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int checks = 0;
  int errors = 0;
  int q8[$];
  int q4[$];

  pipelined_carry_adder #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(vo8), .out_ready(or8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );
  pipelined_carry_adder #(.WIDTH(4), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(vo4), .out_ready(or4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  // result packed as sum | cout << w | overflow << (w+1)
  function automatic int ref_op(int w, int av, int bv, int c, int s);
    int m = 1 << w;
    int h = m / 2;
    int sa = (av >= h) ? av - m : av;
    int sb = (bv >= h) ? bv - m : bv;
    int r = s != 0 ? av - bv - c : av + bv + c;
    int sr = s != 0 ? sa - sb - c : sa + sb + c;
    int co = s != 0 ? int'(av >= bv + c) : int'(r >= m);
    int ov = int'(sr < -h || sr >= h);
    return ((r % m + m) % m) | (co << w) | (ov << (w + 1));
  endfunction

  task automatic set8(input logic iv, input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s, input logic r);
    @(negedge clk);
    iv8 = iv; a8 = av; b8 = bv; cin8 = c; sub8 = s; or8 = r;
    #1;
  endtask

  task automatic set4(input logic iv, input logic [3:0] av, input logic [3:0] bv, input logic c, input logic s, input logic r);
    @(negedge clk);
    iv4 = iv; a4 = av; b4 = bv; cin4 = c; sub4 = s; or4 = r;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; or4 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vo8, sum8, cout8, ovf8} !== 11'd0) begin
      errors++; $display("FAIL reset8_outputs: got %h required 0", {vo8, sum8, cout8, ovf8});
    end
    checks++;
    if ({vo4, sum4, cout4, ovf4} !== 7'd0) begin
      errors++; $display("FAIL reset4_outputs: got %h required 0", {vo4, sum4, cout4, ovf4});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ir8, ir4} !== 2'b11) begin
      errors++; $display("FAIL reset_in_ready: got %b required 11", {ir8, ir4});
    end
  endtask

  task automatic test_directed;
    logic [7:0] va [5] = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h05};
    logic [7:0] vb [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h04};
    logic       vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       vs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] ve [5] = '{{2'b01, 8'h00}, {2'b10, 8'h80}, {2'b11, 8'h7F}, {2'b00, 8'hFE}, {2'b01, 8'h00}};
    for (int j = 0; j < 7; j++) begin
      if (j < 5) set8(1'b1, va[j], vb[j], vc[j], vs[j], 1'b1);
      else set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (vo8 !== (j >= 2)) begin
        errors++; $display("FAIL directed_valid[%0d]: got %b required %b", j, vo8, j >= 2);
      end
      if (j >= 2) begin
        checks++;
        if ({ovf8, cout8, sum8} !== ve[j-2]) begin
          errors++; $display("FAIL directed_result[%0d]: got ov/co/sum %h required %h", j - 2, {ovf8, cout8, sum8}, ve[j-2]);
        end
      end
    end
  endtask

  task automatic test_random8;
    int e, infl, cyc;
    for (cyc = 0; cyc < 300 && (cyc < 250 || q8.size() > 0); cyc++) begin
      if (cyc < 250) set8($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      else set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      infl = q8.size();
      checks++;
      if (ir8 !== (or8 || infl < 2)) begin
        errors++; $display("FAIL rand8_in_ready: got %b required %b (in flight %0d)", ir8, or8 || infl < 2, infl);
      end
      if (vo8 && or8) begin
        checks++;
        if (q8.size() == 0) begin
          errors++; $display("FAIL rand8_extra: unexpected result %h, required none", sum8);
        end else begin
          e = q8.pop_front();
          if (32'({ovf8, cout8, sum8}) !== e) begin
            errors++; $display("FAIL rand8_data: got %h required %h", {ovf8, cout8, sum8}, e);
          end
        end
      end
      if (iv8 && ir8) q8.push_back(ref_op(8, int'(a8), int'(b8), int'(cin8), int'(sub8)));
    end
    checks++;
    if (q8.size() != 0) begin
      errors++; $display("FAIL rand8_drain: got %0d pending required 0", q8.size());
    end
  endtask

  task automatic test_backpressure;
    int nxt = 0, ne = 0, infl;
    logic saw_low = 1'b0;
    for (int i = 0; i < 40 && ne < 6; i++) begin
      set8(nxt < 6, 8'(nxt), 8'(nxt), 1'b0, 1'b0, !(i >= 3 && i <= 6));
      infl = nxt - ne;
      if (!ir8) saw_low = 1'b1;
      checks++;
      if (ir8 !== (or8 || infl < 2)) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b required %b", i, ir8, or8 || infl < 2);
      end
      if (vo8 && or8) begin
        checks++;
        if (sum8 !== 8'(2 * ne)) begin
          errors++; $display("FAIL bp_order[%0d]: got %0d required %0d", ne, sum8, 2 * ne);
        end
        ne++;
      end
      if (iv8 && ir8) nxt++;
    end
    checks++;
    if (ne != 6 || !saw_low) begin
      errors++; $display("FAIL bp_complete: got %0d results, in_ready low seen %b; required 6 and 1", ne, saw_low);
    end
    for (int i = 0; i < 3; i++) begin
      set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (vo8 !== 1'b0) begin
        errors++; $display("FAIL bp_duplicate: got out_valid %b required 0", vo8);
      end
    end
  endtask

  task automatic test_reset_midflight;
    set8(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    set8(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vo8 !== 1'b1 || sum8 !== 8'h33) begin
      errors++; $display("FAIL midrst_before: got valid %b sum %h required 1 33", vo8, sum8);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({vo8, sum8, cout8, ovf8} !== 11'd0) begin
      errors++; $display("FAIL midrst_async: got %h required 0", {vo8, sum8, cout8, ovf8});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    for (int i = 0; i < 6; i++) begin
      set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (vo8 !== 1'b0) begin
        errors++; $display("FAIL midrst_stale[%0d]: got out_valid %b required 0", i, vo8);
      end
    end
  endtask

  task automatic test_exhaustive4;
    int idx = 0, e, infl, cyc;
    logic [9:0] n;
    for (cyc = 0; cyc < 8000 && (idx < 1024 || q4.size() > 0); cyc++) begin
      n = 10'(idx);
      set4(idx < 1024, n[3:0], n[7:4], n[8], n[9], idx >= 1024 || $urandom_range(0, 3) != 0);
      infl = q4.size();
      checks++;
      if (ir4 !== (or4 || infl < 4)) begin
        errors++; $display("FAIL ex4_in_ready: got %b required %b (in flight %0d)", ir4, or4 || infl < 4, infl);
      end
      if (vo4 && or4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++; $display("FAIL ex4_extra: unexpected result %h, required none", sum4);
        end else begin
          e = q4.pop_front();
          if (32'({ovf4, cout4, sum4}) !== e) begin
            errors++; $display("FAIL ex4_data: got %h required %h", {ovf4, cout4, sum4}, e);
          end
        end
      end
      if (iv4 && ir4) begin
        q4.push_back(ref_op(4, int'(a4), int'(b4), int'(cin4), int'(sub4)));
        idx++;
      end
    end
    checks++;
    if (idx != 1024 || q4.size() != 0) begin
      errors++; $display("FAIL ex4_timeout: got %0d accepted %0d pending required 1024 0", idx, q4.size());
    end
  endtask

  task automatic test_back_to_back;
    int e;
    for (int j = 0; j < 40 && (j < 24 || q4.size() > 0); j++) begin
      set4(j < 24, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      checks++;
      if (ir4 !== 1'b1 || vo4 !== (j >= 4 && j < 28)) begin
        errors++; $display("FAIL b2b_rate[%0d]: got ready %b valid %b required 1 %b", j, ir4, vo4, j >= 4 && j < 28);
      end
      if (vo4 && or4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected result %h, required none", sum4);
        end else begin
          e = q4.pop_front();
          if (32'({ovf4, cout4, sum4}) !== e) begin
            errors++; $display("FAIL b2b_data: got %h required %h", {ovf4, cout4, sum4}, e);
          end
        end
      end
      if (iv4 && ir4) q4.push_back(ref_op(4, int'(a4), int'(b4), int'(cin4), int'(sub4)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_backpressure();
    test_reset_midflight();
    test_exhaustive4();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
